// File: rtl/cavlc_coeff_scan_pkg.sv
// Shared types and constants for the CAVLC coefficient scanner.
// The block-length constants name the three supported block shapes.
package cavlc_coeff_scan_pkg;
  localparam int DEF_COEFF_W = 12;
  localparam int DEF_MAX_N   = 16;
  localparam int RUN_W       = 4;

  localparam logic [4:0] LEN_CDC  = 5'd4;
  localparam logic [4:0] LEN_AC   = 5'd15;
  localparam logic [4:0] LEN_LUMA = 5'd16;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SUMMARY, S_EMIT} state_t;

  // Keeps only the signs that belong to the counted trailing ones.
  function automatic logic [2:0] t1_mask(input logic [1:0] n);
    case (n)
      2'd0:    t1_mask = 3'b000;
      2'd1:    t1_mask = 3'b001;
      2'd2:    t1_mask = 3'b011;
      default: t1_mask = 3'b111;
    endcase
  endfunction
endpackage

// File: rtl/cavlc_scan_buf.sv
// Level/run register file: one write port, one asynchronous read port.
module cavlc_scan_buf #(
  parameter int W     = 16,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);
  logic [DEPTH-1:0][W-1:0] mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  mem <= '0;
    else if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/cavlc_coeff_scan.sv
// Scans a zig-zag 4x4 block, reports the CAVLC block summary, then streams
// non-zero levels with run_before from highest frequency down.
module cavlc_coeff_scan
  import cavlc_coeff_scan_pkg::*;
#(
  parameter int COEFF_W = DEF_COEFF_W,
  parameter int MAX_N   = DEF_MAX_N
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      blk_start,
  input  logic [4:0]                blk_len,
  input  logic                      coeff_valid,
  output logic                      coeff_ready,
  input  logic signed [COEFF_W-1:0] coeff,
  output logic                      stat_valid,
  output logic [4:0]                totalcoeff,
  output logic [3:0]                totalzeros,
  output logic [1:0]                trailing_ones,
  output logic [2:0]                t1_sign,
  output logic                      sym_valid,
  input  logic                      sym_ready,
  output logic signed [COEFF_W-1:0] sym_level,
  output logic [3:0]                sym_run,
  output logic                      sym_last,
  output logic                      busy
);
  localparam int AW = $clog2(MAX_N);
  localparam int EW = COEFF_W + RUN_W;

  state_t        state, state_nx;
  logic [4:0]    len, idx, tc, lastpos;
  logic [3:0]    zrun;
  logic [1:0]    t1;
  logic [2:0]    signs;
  logic [AW-1:0] k;
  logic [EW-1:0] rd_data;
  logic [4:0]    st_tc;
  logic [3:0]    st_tz;
  logic [1:0]    st_t1;
  logic [2:0]    st_sg;
  logic [4:0]    tz_full;
  logic          accept, last_acc, is_one, nz;

  assign accept   = (state == S_COLLECT) && coeff_valid;
  assign last_acc = accept && (idx == len - 5'd1);
  assign nz       = (coeff != '0);
  // Exact +1/-1 match; the most negative code is an ordinary level.
  assign is_one   = (coeff == COEFF_W'(1)) || (coeff == {COEFF_W{1'b1}});
  assign tz_full  = (tc == '0) ? '0 : lastpos + 5'd1 - tc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (blk_start) state_nx = S_COLLECT;
      S_COLLECT: if (last_acc) state_nx = S_SUMMARY;
      S_SUMMARY: state_nx = (tc != '0) ? S_EMIT : S_IDLE;
      S_EMIT:    if (sym_ready && k == '0) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len <= '0; idx <= '0; tc <= '0; lastpos <= '0; zrun <= '0;
      t1 <= '0; signs <= '0; k <= '0;
      st_tc <= '0; st_tz <= '0; st_t1 <= '0; st_sg <= '0;
    end else begin
      case (state)
        S_IDLE: if (blk_start) begin
          len     <= (blk_len == '0 || blk_len > 5'(MAX_N)) ? 5'(MAX_N) : blk_len;
          idx     <= '0;
          tc      <= '0;
          zrun    <= '0;
          t1      <= '0;
          signs   <= '0;
          lastpos <= '0;
        end
        S_COLLECT: if (accept) begin
          idx <= idx + 5'd1;
          if (!nz) zrun <= zrun + 4'd1;
          else begin
            tc      <= tc + 5'd1;
            zrun    <= '0;
            lastpos <= idx;
            // Three most recent ±1 signs always held; a larger level clears the tail.
            if (is_one) begin
              t1    <= (t1 == 2'd3) ? 2'd3 : t1 + 2'd1;
              signs <= {signs[1:0], coeff[COEFF_W-1]};
            end else begin
              t1    <= '0;
              signs <= '0;
            end
          end
        end
        S_SUMMARY: begin
          st_tc <= tc;
          st_tz <= tz_full[3:0];
          st_t1 <= t1;
          st_sg <= signs & t1_mask(t1);
          k     <= AW'(tc - 5'd1);
        end
        S_EMIT: if (sym_ready && k != '0) k <= k - 1'b1;
        default: ;
      endcase
    end
  end

  cavlc_scan_buf #(.W(EW), .DEPTH(MAX_N)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (accept && nz),
    .wr_addr (tc[AW-1:0]),
    .wr_data ({coeff, zrun}),
    .rd_addr (k),
    .rd_data (rd_data)
  );

  // Live values during SUMMARY, held copies afterwards.
  assign coeff_ready   = (state == S_COLLECT);
  assign stat_valid    = (state == S_SUMMARY);
  assign busy          = (state != S_IDLE);
  assign totalcoeff    = stat_valid ? tc : st_tc;
  assign totalzeros    = stat_valid ? tz_full[3:0] : st_tz;
  assign trailing_ones = stat_valid ? t1 : st_t1;
  assign t1_sign       = stat_valid ? (signs & t1_mask(t1)) : st_sg;

  assign sym_valid = (state == S_EMIT);
  assign sym_level = sym_valid ? rd_data[EW-1:RUN_W] : '0;
  assign sym_run   = sym_valid ? rd_data[RUN_W-1:0] : '0;
  assign sym_last  = sym_valid && (k == '0);
endmodule

// File: tb/tb_cavlc_coeff_scan.sv
// Randomised scoreboard bench for cavlc_coeff_scan with a list-based reference model.
module tb_cavlc_coeff_scan;
  localparam int CW = 12;
  typedef struct {int tc; int tz; int t1; int sg;} stat_t;
  typedef struct {int lvl; int run; bit last;} sym_t;
  typedef logic signed [CW-1:0] blk_t [16];

  logic clk = 0, rst_n = 0, blk_start = 0, coeff_valid = 0, sym_ready = 0;
  logic [4:0] blk_len = '0;
  logic signed [CW-1:0] coeff = '0;
  logic coeff_ready, stat_valid, sym_valid, sym_last, busy;
  logic [4:0] totalcoeff;
  logic [3:0] totalzeros, sym_run;
  logic [1:0] trailing_ones;
  logic [2:0] t1_sign;
  logic signed [CW-1:0] sym_level;

  cavlc_coeff_scan dut (
    .clk(clk), .rst_n(rst_n), .blk_start(blk_start), .blk_len(blk_len),
    .coeff_valid(coeff_valid), .coeff_ready(coeff_ready), .coeff(coeff),
    .stat_valid(stat_valid), .totalcoeff(totalcoeff), .totalzeros(totalzeros),
    .trailing_ones(trailing_ones), .t1_sign(t1_sign), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .sym_level(sym_level), .sym_run(sym_run),
    .sym_last(sym_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  stat_t stat_q[$];
  sym_t  sym_q[$];
  int checks = 0, failures = 0, last_acc_cyc = 0, rdy_mode = 0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: work from the list of non-zero positions, not a running state.
  function automatic void model(input blk_t c, input int L);
    int pos[$]; int lv[$]; stat_t s; sym_t y; int j;
    for (int i = 0; i < L; i++)
      if (c[i] != 0) begin pos.push_back(i); lv.push_back(int'(c[i])); end
    s.tc = pos.size(); s.tz = 0; s.t1 = 0; s.sg = 0;
    if (s.tc > 0)
      for (int i = 0; i < pos[s.tc-1]; i++) if (c[i] == 0) s.tz++;
    j = s.tc - 1;
    while (j >= 0 && s.t1 < 3) begin
      if (lv[j] != 1 && lv[j] != -1) break;
      if (lv[j] < 0) s.sg |= (1 << s.t1);
      s.t1++; j--;
    end
    stat_q.push_back(s);
    for (int m = s.tc - 1; m >= 0; m--) begin
      y.lvl = lv[m];
      if (m == 0) y.run = pos[m]; else y.run = pos[m] - pos[m-1] - 1;
      y.last = (m == 0);
      sym_q.push_back(y);
    end
  endfunction

  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       sym_ready = 1'b1;
      1:       sym_ready = ~sym_ready;
      default: sym_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops expectations whenever the DUT presents a result.
  initial begin
    bit stalled, chk_next, exp_more;
    int p_lvl, p_run; bit p_last;
    stat_t es; sym_t ey;
    stalled = 0; chk_next = 0; exp_more = 0; p_lvl = 0; p_run = 0; p_last = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk(!(|{coeff_ready, stat_valid, totalcoeff, totalzeros, trailing_ones, t1_sign,
                sym_valid, sym_level, sym_run, sym_last, busy}), "reset_outputs_zero", 1, 0);
        stalled = 0; chk_next = 0;
      end else begin
        if (chk_next) begin
          chk(sym_valid == exp_more, "sym_valid_after_summary", sym_valid, exp_more);
          chk(busy == exp_more, "busy_after_summary", busy, exp_more);
          chk_next = 0;
        end
        if (stalled) begin
          chk(sym_valid && int'(sym_level) == p_lvl && int'(sym_run) == p_run && sym_last == p_last,
              "sym_stable_in_stall", int'(sym_level), p_lvl);
        end
        if (stat_valid) begin
          if (stat_q.size() == 0) chk(0, "unexpected_stat", 1, 0);
          else begin
            es = stat_q.pop_front();
            chk(int'(totalcoeff) == es.tc, "totalcoeff", int'(totalcoeff), es.tc);
            chk(int'(totalzeros) == es.tz, "totalzeros", int'(totalzeros), es.tz);
            chk(int'(trailing_ones) == es.t1, "trailing_ones", int'(trailing_ones), es.t1);
            chk(int'(t1_sign) == es.sg, "t1_sign", int'(t1_sign), es.sg);
            chk(cyc == last_acc_cyc, "stat_latency", cyc, last_acc_cyc);
            chk_next = 1; exp_more = (es.tc > 0);
          end
        end
        if (sym_valid && sym_ready) begin
          if (sym_q.size() == 0) chk(0, "unexpected_sym", int'(sym_level), 0);
          else begin
            ey = sym_q.pop_front();
            chk(int'(sym_level) == ey.lvl, "sym_level", int'(sym_level), ey.lvl);
            chk(int'(sym_run) == ey.run, "sym_run", int'(sym_run), ey.run);
            chk(sym_last == ey.last, "sym_last", sym_last, ey.last);
          end
        end
        stalled = sym_valid && !sym_ready;
        p_lvl = int'(sym_level); p_run = int'(sym_run); p_last = sym_last;
      end
    end
  end

  task automatic issue_block(input blk_t c, input logic [4:0] blen, input bit gap);
    int L, i, n; bit acc;
    L = (blen == 0 || blen > 16) ? 16 : int'(blen);
    i = 0; n = 0;
    model(c, L);
    while (busy && n < 300) begin @(negedge clk); n++; end
    chk(!busy, "idle_before_start", busy, 0);
    @(negedge clk); blk_start = 1; blk_len = blen;
    @(posedge clk); #1; blk_start = 0;
    n = 0;
    while (i < L && n < 400) begin
      coeff_valid = gap ? (n % 3 == 0) : 1'b1;
      coeff = c[i];
      if (gap && n % 5 == 2) begin blk_start = 1; blk_len = 5'($urandom); end
      @(negedge clk);
      acc = coeff_valid && coeff_ready;
      if (acc) last_acc_cyc = cyc + 1;
      @(posedge clk); #1;
      blk_start = 0;
      if (acc) i++;
      n++;
    end
    coeff_valid = 0;
    if (i < L) chk(0, "feed_timeout", i, L);
  endtask

  task automatic wait_done(input bit gap);
    int n; bit pulsed;
    n = 0; pulsed = 0;
    while ((busy || stat_q.size() != 0 || sym_q.size() != 0) && n < 300) begin
      @(negedge clk); n++;
      if (blk_start) blk_start = 0;
      else if (gap && !pulsed && sym_valid) begin blk_start = 1; blk_len = 5'd4; pulsed = 1; end
    end
    blk_start = 0;
    chk(!busy && sym_q.size() == 0 && stat_q.size() == 0, "drain", sym_q.size() + stat_q.size(), 0);
  endtask

  task automatic run_block(input blk_t c, input logic [4:0] blen, input bit gap);
    issue_block(c, blen, gap);
    wait_done(gap);
  endtask

  function automatic logic signed [CW-1:0] rnd_coeff();
    int r;
    r = $urandom_range(0, 9);
    if (r < 5) return '0;
    if (r < 7) return 12'sd1;
    if (r == 7) return -12'sd1;
    if (r == 8) return ($urandom_range(0, 1) != 0) ? -12'sd2048 : 12'sd2047;
    return CW'($urandom);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    blk_t v1, v2, v3, v4, vr;
    logic [4:0] bl;
    int n;
    v1 = '{0,3,-1,0,0,-1,1,0,1,0,0,0,0,0,0,0};
    v2 = '{default: 0};
    v3 = '{0,0,-2,1,0,0,0,0,0,0,0,0,0,0,0,0};
    v4 = '{default: 1};
    repeat (3) @(negedge clk);
    #1 rst_n = 1;

    rdy_mode = 0; run_block(v1, 5'd16, 0);
    run_block(v2, 5'd15, 0);
    run_block(v3, 5'd4, 0);
    rdy_mode = 1; run_block(v4, 5'd16, 0);
    rdy_mode = 0; run_block(v1, 5'd16, 1);

    // Abort mid-EMIT, then confirm the next block is clean.
    rdy_mode = 1; issue_block(v1, 5'd16, 0);
    n = 0;
    while (!sym_valid && n < 50) begin @(negedge clk); n++; end
    chk(sym_valid, "reach_emit_before_reset", sym_valid, 1);
    @(negedge clk); #1 rst_n = 0;
    stat_q.delete(); sym_q.delete();
    repeat (3) @(negedge clk);
    #1 rst_n = 1;
    rdy_mode = 0; run_block(v3, 5'd4, 0);

    for (int b = 0; b < 40; b++) begin
      case ($urandom_range(0, 5))
        0: bl = 5'd4;
        1: bl = 5'd15;
        2: bl = 5'd16;
        3: bl = 5'd0;
        4: bl = 5'd20;
        default: bl = 5'($urandom_range(1, 16));
      endcase
      for (int i = 0; i < 16; i++) vr[i] = rnd_coeff();
      rdy_mode = $urandom_range(0, 2);
      run_block(vr, bl, $urandom_range(0, 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
